// File: rtl/psram_reader.sv
// Fast Quad Read (0xEB) burst engine for a QSPI PSRAM; SCK runs at sys_clk/2.
// Optional macro PSRAM_RD_CHECKSUM_EN adds checksum_o, the XOR of all bytes in the burst.
module psram_reader #(
  parameter int WAIT_CYCLES = 6,
  parameter int LEN_W       = 8
) (
  input  logic             sys_clk_i,
  input  logic             sys_reset_n_i,
  input  logic             start_i,
  input  logic [23:0]      addr_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  output logic [7:0]       rd_data_o,
  output logic             rd_valid_o,
  output logic             done_o,
  output logic             ce_n_o,
  output logic             clk_o,
  output logic [3:0]       sio_out_o,
  output logic [3:0]       sio_oe_o,
`ifdef PSRAM_RD_CHECKSUM_EN
  output logic [7:0]       checksum_o,
`endif
  input  logic [3:0]       sio_in_i
);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_WAIT, S_DATA, S_GAP} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_CYCLES - 1);
  localparam logic [7:0] CMD_OP    = 8'hEB;

  state_t           state_q;
  logic             ph_q;      // 0: SCK low half, 1: SCK high half
  logic [7:0]       cnt_q;
  logic [31:0]      sr_q;      // opcode followed by address, shifted out MSB first
  logic [3:0]       hi_q;
  logic [LEN_W-1:0] len_q;
  logic             busy_q, rd_valid_q, done_q, ce_n_q, clk_q;
  logic [7:0]       rd_data_q;
  logic [3:0]       sio_out_q, sio_oe_q;
`ifdef PSRAM_RD_CHECKSUM_EN
  logic [7:0]       cs_q;
`endif

  logic [31:0] sr1_d, sr4_d;
  logic [7:0]  rx_byte_d;

  assign sr1_d     = sr_q << 1;
  assign sr4_d     = sr_q << 4;
  assign rx_byte_d = {hi_q, sio_in_i};

  always_ff @(posedge sys_clk_i) begin
    if (!sys_reset_n_i) begin
      state_q    <= S_IDLE;
      ph_q       <= 1'b0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      ce_n_q     <= 1'b1;
      clk_q      <= 1'b0;
      rd_data_q  <= '0;
      sio_out_q  <= '0;
      sio_oe_q   <= '0;
`ifdef PSRAM_RD_CHECKSUM_EN
      cs_q       <= '0;
`endif
    end else begin
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
`ifdef PSRAM_RD_CHECKSUM_EN
            cs_q   <= '0;
`endif
            if (len_i == '0) begin
              // Empty burst: never touch the bus, just pulse done.
              done_q  <= 1'b1;
              state_q <= S_GAP;
            end else begin
              state_q   <= S_CMD;
              ce_n_q    <= 1'b0;
              clk_q     <= 1'b0;
              ph_q      <= 1'b0;
              sr_q      <= {CMD_OP, addr_i};
              sio_oe_q  <= 4'b0001;
              sio_out_q <= {3'b000, CMD_OP[7]};
              len_q     <= len_i;
            end
          end
        end
        S_GAP: begin
          if (cnt_q == '0) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        default: begin
          if (!ph_q) begin
            clk_q <= 1'b1;
            ph_q  <= 1'b1;
          end else begin
            // End of the SCK high half: sample sio_in and set up the next period.
            clk_q <= 1'b0;
            ph_q  <= 1'b0;
            case (state_q)
              S_CMD: begin
                sr_q <= sr1_d;
                if (cnt_q == 8'd7) begin
                  state_q   <= S_ADDR;
                  cnt_q     <= '0;
                  sio_oe_q  <= 4'b1111;
                  sio_out_q <= sr1_d[31:28];
                end else begin
                  cnt_q     <= cnt_q + 8'd1;
                  sio_out_q <= {3'b000, sr1_d[31]};
                end
              end
              S_ADDR: begin
                if (cnt_q == 8'd5) begin
                  state_q   <= (WAIT_CYCLES == 0) ? S_DATA : S_WAIT;
                  cnt_q     <= '0;
                  sio_oe_q  <= 4'b0000;
                  sio_out_q <= 4'b0000;
                end else begin
                  cnt_q     <= cnt_q + 8'd1;
                  sr_q      <= sr4_d;
                  sio_out_q <= sr4_d[31:28];
                end
              end
              S_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                  state_q <= S_DATA;
                  cnt_q   <= '0;
                end else begin
                  cnt_q <= cnt_q + 8'd1;
                end
              end
              S_DATA: begin
                if (cnt_q == '0) begin
                  hi_q  <= sio_in_i;
                  cnt_q <= 8'd1;
                end else begin
                  rd_data_q  <= rx_byte_d;
                  rd_valid_q <= 1'b1;
`ifdef PSRAM_RD_CHECKSUM_EN
                  cs_q       <= cs_q ^ rx_byte_d;
`endif
                  len_q      <= len_q - LEN_W'(1);
                  if (len_q == LEN_W'(1)) begin
                    // Last byte: release CE now, then hold it high for tCPH.
                    done_q  <= 1'b1;
                    ce_n_q  <= 1'b1;
                    state_q <= S_GAP;
                    cnt_q   <= 8'd2;
                  end else begin
                    cnt_q <= '0;
                  end
                end
              end
              default: state_q <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign done_o     = done_q;
  assign ce_n_o     = ce_n_q;
  assign clk_o      = clk_q;
  assign sio_out_o  = sio_out_q;
  assign sio_oe_o   = sio_oe_q;
`ifdef PSRAM_RD_CHECKSUM_EN
  assign checksum_o = cs_q;
`endif

endmodule
